// File: rtl/hazard_scoreboard.sv
// EX-stage operand forwarding select, hazard stall and multi-cycle busy scoreboard.
// Optional stall-cycle counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
  parameter  int NUM_FWD  = 2,
  parameter  int RA_W     = 5,
  parameter  int MAX_OUT  = 2,
  parameter  int PCNT_W   = 32,
  localparam int SEL_W    = $clog2(NUM_FWD+1),
  localparam int NUM_REGS = 2**RA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RA_W-1:0]         rs1,
  input  logic [RA_W-1:0]         rs2,
  input  logic                    rs1_used,
  input  logic                    rs2_used,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]      fwd_wr,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic                    lat_issue,
  input  logic [RA_W-1:0]         lat_issue_rd,
  input  logic                    lat_done,
  input  logic [RA_W-1:0]         lat_done_rd,
  input  logic                    perf_clr,
  output logic [SEL_W-1:0]        operand_a_cntl,
  output logic [SEL_W-1:0]        operand_b_cntl,
  output logic                    stall,
  output logic                    lat_full,
  output logic [NUM_REGS-1:0]     busy_vec,
  output logic                    sb_err,
  output logic [PCNT_W-1:0]       perf_fwd_stall_cnt,
  output logic [PCNT_W-1:0]       perf_lat_stall_cnt
);

  localparam int CNT_W = $clog2(MAX_OUT+1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0] sel_a, sel_b;
  logic             rdy_a, rdy_b;
  logic             fwd_stall, lat_stall;
  logic             full, issue_ok, done_ok;

  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (rs1_used && rs1 != '0 && fwd_wr[k] &&
          fwd_rd[k*RA_W +: RA_W] == rs1) begin
        sel_a = SEL_W'(k+1);
        rdy_a = fwd_ready[k];
      end
      if (rs2_used && rs2 != '0 && fwd_wr[k] &&
          fwd_rd[k*RA_W +: RA_W] == rs2) begin
        sel_b = SEL_W'(k+1);
        rdy_b = fwd_ready[k];
      end
    end
  end

  assign full      = (cnt_q == CNT_W'(MAX_OUT));
  assign fwd_stall = ~rdy_a | ~rdy_b;
  assign lat_stall = (rs1_used && rs1 != '0 && busy_q[rs1]) |
                     (rs2_used && rs2 != '0 && busy_q[rs2]) |
                     (lat_issue && full);

  assign issue_ok = lat_issue && !full;
  assign done_ok  = lat_done && cnt_q != '0 &&
                    !(lat_done_rd != '0 && !busy_q[lat_done_rd]);

  always_comb begin
    busy_d = busy_q;
    if (done_ok)
      busy_d[lat_done_rd] = 1'b0;
    if (issue_ok && lat_issue_rd != '0)
      busy_d[lat_issue_rd] = 1'b1;
    cnt_d = cnt_q + CNT_W'(issue_ok) - CNT_W'(done_ok);
    err_d = err_q |
            (lat_issue && full) |
            (lat_done && cnt_q == '0) |
            (lat_done && lat_done_rd != '0 && !busy_q[lat_done_rd]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign operand_a_cntl = sel_a;
  assign operand_b_cntl = sel_b;
  assign stall          = fwd_stall | lat_stall;
  assign lat_full       = full;
  assign busy_vec       = busy_q;
  assign sb_err         = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PCNT_W-1:0] fcnt_q, fcnt_d;
  logic [PCNT_W-1:0] lcnt_q, lcnt_d;

  // Lat stalls are only charged when no forward stall hides them.
  always_comb begin
    fcnt_d = fcnt_q;
    lcnt_d = lcnt_q;
    if (perf_clr) begin
      fcnt_d = '0;
      lcnt_d = '0;
    end else if (fwd_stall) begin
      if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
    end else if (lat_stall) begin
      if (lcnt_q != '1) lcnt_d = lcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      lcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      lcnt_q <= lcnt_d;
    end
  end

  assign perf_fwd_stall_cnt = fcnt_q;
  assign perf_lat_stall_cnt = lcnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr    = perf_clr;
  assign perf_fwd_stall_cnt = '0;
  assign perf_lat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// Expected selects/stalls are queued per cycle and popped when outputs settle.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2;
  logic        rs1_used, rs2_used;
  logic [9:0]  fwd_rd;
  logic [1:0]  fwd_wr, fwd_ready;
  logic        lat_issue, lat_done, perf_clr;
  logic [4:0]  lat_issue_rd, lat_done_rd;
  logic [1:0]  operand_a_cntl, operand_b_cntl;
  logic        stall, lat_full, sb_err;
  logic [31:0] busy_vec;
  logic [3:0]  perf_fwd_stall_cnt, perf_lat_stall_cnt;

  hazard_scoreboard #(
    .NUM_FWD(2), .RA_W(5), .MAX_OUT(2), .PCNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .fwd_rd(fwd_rd), .fwd_wr(fwd_wr), .fwd_ready(fwd_ready),
    .lat_issue(lat_issue), .lat_issue_rd(lat_issue_rd),
    .lat_done(lat_done), .lat_done_rd(lat_done_rd),
    .perf_clr(perf_clr),
    .operand_a_cntl(operand_a_cntl), .operand_b_cntl(operand_b_cntl),
    .stall(stall), .lat_full(lat_full), .busy_vec(busy_vec),
    .sb_err(sb_err),
    .perf_fwd_stall_cnt(perf_fwd_stall_cnt),
    .perf_lat_stall_cnt(perf_lat_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
    logic       fs;
    logic       ls;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic [3:0] fc = '0;
  logic [3:0] lc = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    fwd_rd = '0; fwd_wr = '0; fwd_ready = 2'b11;
    lat_issue = 1'b0; lat_issue_rd = '0;
    lat_done = 1'b0; lat_done_rd = '0;
    perf_clr = 1'b0;
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic step(input string tag, input logic [1:0] ea, eb,
                      input logic efs, els);
    exp_t e;
    q.push_back('{tag, ea, eb, efs, els});
    #1;
    if (q.size() == 0) begin
      check({tag, "_q"}, 0, 1);
    end else begin
      e = q.pop_front();
      check({e.tag, "_a"}, operand_a_cntl, e.a);
      check({e.tag, "_b"}, operand_b_cntl, e.b);
      check({e.tag, "_stall"}, stall, e.fs | e.ls);
    end
    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    if (perf_clr) begin
      fc = '0;
      lc = '0;
    end else if (efs) begin
      fc = fc + 4'(fc != 4'hf);
    end else if (els) begin
      lc = lc + 4'(lc != 4'hf);
    end
`endif
    #1;
    check({tag, "_fcnt"}, perf_fwd_stall_cnt, fc);
    check({tag, "_lcnt"}, perf_lat_stall_cnt, lc);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    fc = '0;
    lc = '0;
    check({tag, "_busy"}, busy_vec, 0);
    check({tag, "_full"}, lat_full, 0);
    check({tag, "_err"}, sb_err, 0);
    check({tag, "_fcnt"}, perf_fwd_stall_cnt, 0);
    check({tag, "_lcnt"}, perf_lat_stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    check("rst_busy", busy_vec, 0);
    check("rst_full", lat_full, 0);
    check("rst_err", sb_err, 0);
    check("rst_a", operand_a_cntl, 0);
    check("rst_stall", stall, 0);
    check("rst_fcnt", perf_fwd_stall_cnt, 0);
    check("rst_lcnt", perf_lat_stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Youngest stage wins, older stage used when younger not writing.
    rs1 = 5'd5; rs1_used = 1'b1;
    fwd_rd = {5'd5, 5'd5}; fwd_wr = 2'b11; fwd_ready = 2'b11;
    step("fwd_mem", 2'd1, 2'd0, 1'b0, 1'b0);
    fwd_wr = 2'b10;
    step("fwd_wb", 2'd2, 2'd0, 1'b0, 1'b0);

    // Load-use: younger non-ready match is not overridden by ready WB.
    idle();
    rs2 = 5'd7; rs2_used = 1'b1;
    fwd_rd = {5'd7, 5'd7}; fwd_wr = 2'b11; fwd_ready = 2'b10;
    for (int i = 0; i < 3; i++) step("load_use", 2'd0, 2'd1, 1'b1, 1'b0);
    fwd_ready = 2'b11;
    step("load_rdy", 2'd0, 2'd1, 1'b0, 1'b0);

    // x0 never forwards.
    idle();
    rs1_used = 1'b1; rs2_used = 1'b1; fwd_wr = 2'b11; fwd_ready = 2'b00;
    step("x0", 2'd0, 2'd0, 1'b0, 1'b0);

    // Divide to x9, consumer stalls cycles 1..10.
    idle();
    lat_issue = 1'b1; lat_issue_rd = 5'd9;
    step("div_iss", 2'd0, 2'd0, 1'b0, 1'b0);
    check("div_busy", busy_vec, 32'h0000_0200);
    lat_issue = 1'b0; rs1 = 5'd9; rs1_used = 1'b1;
    for (int i = 1; i < 10; i++) step("div_wait", 2'd0, 2'd0, 1'b0, 1'b1);
    lat_done = 1'b1; lat_done_rd = 5'd9;
    step("div_done", 2'd0, 2'd0, 1'b0, 1'b1);
    lat_done = 1'b0;
    step("div_rel", 2'd0, 2'd0, 1'b0, 1'b0);
    check("div_clr", busy_vec, 0);

    // Done with nothing outstanding is sticky until reset.
    idle();
    lat_done = 1'b1;
    step("done_empty", 2'd0, 2'd0, 1'b0, 1'b0);
    check("err_set", sb_err, 1);
    lat_done = 1'b0;
    step("err_hold", 2'd0, 2'd0, 1'b0, 1'b0);
    check("err_held", sb_err, 1);
    do_reset("rst1");

    // Fill to MAX_OUT, same-cycle issue/done, and issue while full.
    idle();
    lat_issue = 1'b1; lat_issue_rd = 5'd3;
    step("iss3", 2'd0, 2'd0, 1'b0, 1'b0);
    lat_done = 1'b1; lat_done_rd = 5'd3;
    step("iss_done3", 2'd0, 2'd0, 1'b0, 1'b0);
    check("same_busy", busy_vec, 32'h0000_0008);
    check("same_full", lat_full, 0);
    lat_done = 1'b0; lat_issue_rd = 5'd4;
    step("iss4", 2'd0, 2'd0, 1'b0, 1'b0);
    check("full_set", lat_full, 1);
    check("full_busy", busy_vec, 32'h0000_0018);
    check("full_err", sb_err, 0);
    lat_issue_rd = 5'd5;
    step("iss_full", 2'd0, 2'd0, 1'b0, 1'b1);
    check("ovf_err", sb_err, 1);
    check("ovf_busy", busy_vec, 32'h0000_0018);
    lat_issue = 1'b0; lat_done = 1'b1; lat_done_rd = 5'd3;
    step("done3", 2'd0, 2'd0, 1'b0, 1'b0);
    check("done3_full", lat_full, 0);
    lat_done_rd = 5'd4;
    step("done4", 2'd0, 2'd0, 1'b0, 1'b0);
    check("done4_busy", busy_vec, 0);
    do_reset("rst2");

    // Done to an idle register is an error and is dropped.
    idle();
    lat_issue = 1'b1; lat_issue_rd = 5'd8;
    step("iss8", 2'd0, 2'd0, 1'b0, 1'b0);
    lat_issue = 1'b0; lat_done = 1'b1; lat_done_rd = 5'd6;
    step("done6", 2'd0, 2'd0, 1'b0, 1'b0);
    check("stray_err", sb_err, 1);
    check("stray_busy", busy_vec, 32'h0000_0100);
    lat_done = 1'b0;

    // Forward and lat stall together: forward wins attribution, saturates.
    rs1 = 5'd5; rs1_used = 1'b1; rs2 = 5'd8; rs2_used = 1'b1;
    fwd_rd = {5'd0, 5'd5}; fwd_wr = 2'b01; fwd_ready = 2'b00;
    for (int i = 0; i < 17; i++) step("sat", 2'd1, 2'd0, 1'b1, 1'b1);
    perf_clr = 1'b1;
    step("pclr", 2'd1, 2'd0, 1'b1, 1'b1);
    perf_clr = 1'b0;
    check("pre_rst_busy", busy_vec, 32'h0000_0100);
    do_reset("rst_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
